// File: rtl/fifo_test_pkg.sv
// -----------------------------------------------------------------------------
// fifo_test_pkg
//   Definitions shared by the FIFO test-pattern writer and reader stages:
//   the state encoding both ends report on their debug taps, the packet
//   header bytes and the width of lengths and counters.
// -----------------------------------------------------------------------------
package fifo_test_pkg;

   localparam int         LEN_W = 12;
   localparam logic [7:0] HEAD0 = 8'h55;
   localparam logic [7:0] HEAD1 = 8'hAA;

   // Encoding is shared with the writer stage; encoding 1 is unused.
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WORK = 2'd2,
      LAST = 2'd3
   } state_t;

endpackage

// File: rtl/fifo_pattern_gen.sv
// -----------------------------------------------------------------------------
// fifo_pattern_gen
//   Combinational definition of the test packet: byte index -> expected byte.
//   Index 0 and 1 carry the header, every later index carries its own low
//   eight bits (so payloads longer than 256 bytes wrap).
//
// Ports:
//   idx       in  LEN_W  byte index within the packet
//   exp_byte  out 8      expected byte at that index
// -----------------------------------------------------------------------------
module fifo_pattern_gen #(
   parameter int         LEN_W = fifo_test_pkg::LEN_W,
   parameter logic [7:0] HEAD0 = fifo_test_pkg::HEAD0,
   parameter logic [7:0] HEAD1 = fifo_test_pkg::HEAD1
) (
   input  logic [LEN_W-1:0] idx,
   output logic [7:0]       exp_byte
);

   always_comb begin
      // NOTE: every output of an always_comb gets a value on every path
      // (default first) so no latch can be inferred.
      exp_byte = idx[7:0];
      if (idx == '0) begin
         exp_byte = HEAD0;
      end else if (idx == LEN_W'(1)) begin
         exp_byte = HEAD1;
      end
   end

endmodule

// File: rtl/fifo_read_check.sv
// -----------------------------------------------------------------------------
// fifo_read_check
//   Reader stage of the FIFO test: on a start request drains one packet from
//   a standard (non-FWFT) FIFO and checks every byte against the test pattern.
//   Reports completion on the fs/fd handshake, a sticky mismatch flag, a
//   saturating mismatch count and debug taps.
//
// Ports:
//   clk          in   1      system clock, rising edge
//   rst_n        in   1      asynchronous active-low reset
//   fifo_rxd     in   8      FIFO read data, valid one cycle after fifo_rden
//   fifo_empty   in   1      FIFO empty flag
//   fifo_rden    out  1      FIFO read strobe
//   fs           in   1      start request (level)
//   fd           out  1      packet done (level, high in LAST)
//   data_len     in   LEN_W  packet length in bytes, sampled at start
//   err          out  1      sticky mismatch flag for the current packet
//   err_cnt      out  LEN_W  mismatching bytes, saturates at all-ones
//   state_fr     out  4      current state, zero-extended
//   fifo_num_fr  out  LEN_W  bytes received and checked so far
// -----------------------------------------------------------------------------
module fifo_read_check #(
   parameter int         LEN_W = fifo_test_pkg::LEN_W,
   parameter logic [7:0] HEAD0 = fifo_test_pkg::HEAD0,
   parameter logic [7:0] HEAD1 = fifo_test_pkg::HEAD1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [7:0]       fifo_rxd,
   input  logic             fifo_empty,
   output logic             fifo_rden,
   input  logic             fs,
   output logic             fd,
   input  logic [LEN_W-1:0] data_len,
   output logic             err,
   output logic [LEN_W-1:0] err_cnt,
   output logic [3:0]       state_fr,
   output logic [LEN_W-1:0] fifo_num_fr
);

   import fifo_test_pkg::*;

   state_t             state_q;
   state_t             state_d;
   logic [LEN_W-1:0]   len_r;
   logic [LEN_W-1:0]   issue_cnt;
   logic [LEN_W-1:0]   recv_cnt;
   logic               rd_vld;
   logic [7:0]         exp_byte;
   logic               last_byte;
   logic               mismatch;

   fifo_pattern_gen #(
      .LEN_W (LEN_W),
      .HEAD0 (HEAD0),
      .HEAD1 (HEAD1)
   ) u_pattern (
      .idx      (recv_cnt),
      .exp_byte (exp_byte)
   );

   // Read issue is stalled only by empty or by having requested the whole
   // packet; bytes already in flight are always checked.
   assign fifo_rden = (state_q == WORK) && !fifo_empty && (issue_cnt < len_r);

   // The final byte is checked on the same edge that moves to LAST.
   assign last_byte = rd_vld && (recv_cnt == len_r - LEN_W'(1));
   assign mismatch  = rd_vld && (fifo_rxd != exp_byte);

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE: begin
            if (fs) begin
               state_d = (data_len == '0) ? LAST : WORK;
            end
         end
         WORK: begin
            if (last_byte) begin
               state_d = LAST;
            end
         end
         LAST: begin
            if (!fs) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
      end else begin
         // NOTE: state registers use non-blocking assignment so every flop
         // samples pre-edge values regardless of process order.
         state_q <= state_d;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         len_r     <= '0;
         issue_cnt <= '0;
         recv_cnt  <= '0;
         rd_vld    <= 1'b0;
         err       <= 1'b0;
         err_cnt   <= '0;
      end else begin
         rd_vld <= fifo_rden;
         if (fifo_rden) begin
            issue_cnt <= issue_cnt + LEN_W'(1);
         end

         if (state_q == IDLE) begin
            if (fs) begin
               len_r     <= data_len;
               issue_cnt <= '0;
               recv_cnt  <= '0;
               err       <= 1'b0;
               err_cnt   <= '0;
            end
         end else if (state_q == WORK && rd_vld) begin
            recv_cnt <= recv_cnt + LEN_W'(1);
            if (mismatch) begin
               err <= 1'b1;
               if (err_cnt != '1) begin
                  err_cnt <= err_cnt + LEN_W'(1);
               end
            end
         end
      end
   end

   assign fd          = (state_q == LAST);
   assign state_fr    = {2'b00, state_q};
   assign fifo_num_fr = recv_cnt;

endmodule
